// File: rtl/bmp_pkg.sv
// Shared constants and types for the BMP pixel processor.
// Widths, mode encodings and FSM state type.
package bmp_pkg;

    localparam int DATA_BUS_SIZE   = 32;
    localparam int BYTES_PER_PIXEL = 3;
    localparam int BMP_HDR_SIZE    = 54;

    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_THRESH = 2'b01;
    localparam logic [1:0] MODE_GRAY   = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        STREAM,
        FLUSH
    } state_t;

endpackage

// File: rtl/bmp_pixel_proc_if.sv
// Scheduler <-> pixel processor word bus.
// master = scheduler side, slave = processor side.
interface bmp_pixel_proc_if #(
    parameter int DW = 32
) ();

    logic [DW-1:0] data_to_processor;
    logic          scheduler_2_proc_vld;
    logic [1:0]    mode;
    logic [7:0]    data_proc;
    logic          done;
    logic [DW-1:0] data_from_processor;
    logic          vld_pr;

    modport master (
        output data_to_processor,
        output scheduler_2_proc_vld,
        output mode,
        output data_proc,
        output done,
        input  data_from_processor,
        input  vld_pr
    );

    modport slave (
        input  data_to_processor,
        input  scheduler_2_proc_vld,
        input  mode,
        input  data_proc,
        input  done,
        output data_from_processor,
        output vld_pr
    );

endinterface

// File: rtl/bmp_pixel_xform.sv
// Per-pixel transform: luma threshold or grayscale.
// Output bytes are in B,G,R order; unknown modes pass through.
module bmp_pixel_xform
    import bmp_pkg::*;
(
    input  logic [7:0]  b,
    input  logic [7:0]  g,
    input  logic [7:0]  r,
    input  logic [1:0]  mode,
    input  logic [7:0]  thr,
    output logic [23:0] px
);

    logic [9:0] sum;
    logic [7:0] luma;

    always_comb begin
        sum  = {2'b00, b} + {1'b0, g, 1'b0} + {2'b00, r};
        luma = 8'(sum >> 2);
        px   = {r, g, b};
        unique case (1'b1)
            (mode == MODE_THRESH):
                px = (luma >= thr) ? 24'hFFFFFF : 24'h000000;
            (mode == MODE_GRAY):
                px = {3{luma}};
            default: ;
        endcase
    end

endmodule

// File: rtl/bmp_pixel_proc.sv
// 24-bit BMP pixel stream processor over a 32-bit word bus.
// Emits word n once word n+1 (or end of frame) is known.
module bmp_pixel_proc #(
    parameter int DATA_BUS_SIZE   = bmp_pkg::DATA_BUS_SIZE,
    parameter int BYTES_PER_PIXEL = bmp_pkg::BYTES_PER_PIXEL
) (
    input logic             clk,
    input logic             rst_n,
    bmp_pixel_proc_if.slave bus
);

    import bmp_pkg::*;

    state_t state, nxt;

    logic [1:0]               mode_q;
    logic [7:0]               thr_q;
    logic [1:0]               phase_q;
    logic [15:0]              carry_q;
    logic [DATA_BUS_SIZE-1:0] held_q;
    logic [DATA_BUS_SIZE-1:0] out_q;
    logic                     vld_q;

    logic in_frame, mode_ok, start, shift, last, emit;
    logic vld, dn;

    logic [7:0] h0, h1, h2, h3, c2, c3, n0, n1;
    logic [7:0] ab, ag, ar, bb, bg, br;
    logic [23:0] ya, yb;
    logic [DATA_BUS_SIZE-1:0] xw;

    assign vld      = bus.scheduler_2_proc_vld;
    assign dn       = bus.done;
    assign in_frame = (state == FIRST) || (state == STREAM);
    assign mode_ok  = (bus.mode == MODE_THRESH) ||
                      (bus.mode == MODE_GRAY);
    assign start    = (state == IDLE) && vld && mode_ok;
    assign shift    = in_frame && vld;
    assign last     = (in_frame && dn && !vld) ||
                      (state == FLUSH);
    assign emit     = shift || last;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:   if (start) nxt = FIRST;
            FIRST:  begin
                if (dn)       nxt = vld ? FLUSH : IDLE;
                else if (vld) nxt = STREAM;
            end
            STREAM: if (dn) nxt = vld ? FLUSH : IDLE;
            FLUSH:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign h0 = held_q[7:0];
    assign h1 = held_q[15:8];
    assign h2 = held_q[23:16];
    assign h3 = held_q[31:24];
    assign c2 = carry_q[7:0];
    assign c3 = carry_q[15:8];
    assign n0 = bus.data_to_processor[7:0];
    assign n1 = bus.data_to_processor[15:8];

    // phase = held word's first byte position inside its pixel
    always_comb begin
        {ab, ag, ar} = {h0, h1, h2};
        {bb, bg, br} = {h3, n0, n1};
        case (phase_q)
            2'd0: begin
                {ab, ag, ar} = {h0, h1, h2};
                {bb, bg, br} = {h3, n0, n1};
            end
            2'd1: begin
                {ab, ag, ar} = {c3, h0, h1};
                {bb, bg, br} = {h2, h3, n0};
            end
            default: begin
                {ab, ag, ar} = {c2, c3, h0};
                {bb, bg, br} = {h1, h2, h3};
            end
        endcase
    end

    bmp_pixel_xform u_xa (
        .b(ab), .g(ag), .r(ar),
        .mode(mode_q), .thr(thr_q), .px(ya)
    );

    bmp_pixel_xform u_xb (
        .b(bb), .g(bg), .r(br),
        .mode(mode_q), .thr(thr_q), .px(yb)
    );

    // on the last word a pixel missing its tail bytes passes through
    always_comb begin
        xw = '0;
        case (phase_q)
            2'd0: begin
                xw[7:0]   = ya[7:0];
                xw[15:8]  = ya[15:8];
                xw[23:16] = ya[23:16];
                xw[31:24] = last ? h3 : yb[7:0];
            end
            2'd1: begin
                xw[7:0]   = ya[15:8];
                xw[15:8]  = ya[23:16];
                xw[23:16] = last ? h2 : yb[7:0];
                xw[31:24] = last ? h3 : yb[15:8];
            end
            default: begin
                xw[7:0]   = ya[23:16];
                xw[15:8]  = yb[7:0];
                xw[23:16] = yb[15:8];
                xw[31:24] = yb[23:16];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state   <= IDLE;
            mode_q  <= MODE_IDLE;
            thr_q   <= 8'h00;
            phase_q <= 2'd0;
            carry_q <= '0;
            held_q  <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state <= nxt;
            vld_q <= emit;
            if (emit) out_q <= xw;
            if (start) begin
                mode_q  <= bus.mode;
                thr_q   <= bus.data_proc;
                phase_q <= 2'd0;
                carry_q <= '0;
                held_q  <= bus.data_to_processor;
            end else if (shift) begin
                carry_q <= held_q[31:16];
                held_q  <= bus.data_to_processor;
                phase_q <= (phase_q == 2'(BYTES_PER_PIXEL - 1)) ?
                           2'd0 : phase_q + 2'd1;
            end
        end
    end

    assign bus.data_from_processor = out_q;
    assign bus.vld_pr              = vld_q;

endmodule

// File: tb/tb_bmp_pixel_proc.sv
// Bench for bmp_pixel_proc: frame-level byte model plus
// directed literal frames and randomized streams.
module tb_bmp_pixel_proc;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bmp_pixel_proc_if #(.DW(32)) bus ();

    bmp_pixel_proc #(
        .DATA_BUS_SIZE(32),
        .BYTES_PER_PIXEL(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int ncyc = 0;
    bit chk_en = 0;

    logic [31:0] got[$];
    int          gcyc[$];

    logic        exp_vld = 1'b0;
    logic [31:0] exp_data = '0;

    logic [7:0]  fb[$];
    int          nw = 0;
    bit          in_frame = 0;
    bit          flush = 0;
    logic [1:0]  fmode = 2'b00;
    logic [7:0]  fthr = 8'h00;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] px(input int b,
                                      input int g,
                                      input int r);
        int l;
        l = (b + 2 * g + r) / 4;
        if (fmode == 2'b01)
            return (l >= int'(fthr)) ? 8'hFF : 8'h00;
        return l[7:0];
    endfunction

    // byte k is transformed only if its whole pixel is in the frame
    function automatic logic [31:0] word_exp(input int n);
        logic [31:0] w;
        int k, s;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            k = 4 * n + j;
            s = k - (k % 3);
            if (s + 2 < fb.size())
                w[8*j +: 8] = px(fb[s], fb[s+1], fb[s+2]);
            else
                w[8*j +: 8] = fb[k];
        end
        return w;
    endfunction

    task automatic push_word(input logic [31:0] d);
        for (int j = 0; j < 4; j++) fb.push_back(d[8*j +: 8]);
        nw++;
    endtask

    initial begin
        logic v, dn;
        logic [1:0] m;
        forever begin
            @(posedge clk);
            v  = bus.scheduler_2_proc_vld;
            dn = bus.done;
            m  = bus.mode;
            if (rst_n) begin
                in_frame = 0;
                flush    = 0;
                exp_vld  = 1'b0;
                exp_data = '0;
                fb.delete();
                nw = 0;
            end else begin
                exp_vld = 1'b0;
                if (flush) begin
                    exp_data = word_exp(nw - 1);
                    exp_vld  = 1'b1;
                    flush    = 0;
                    in_frame = 0;
                end else if (!in_frame) begin
                    if (v && (m == 2'b01 || m == 2'b10)) begin
                        in_frame = 1;
                        fmode = m;
                        fthr  = bus.data_proc;
                        fb.delete();
                        nw = 0;
                        push_word(bus.data_to_processor);
                    end
                end else if (v) begin
                    push_word(bus.data_to_processor);
                    exp_data = word_exp(nw - 2);
                    exp_vld  = 1'b1;
                    if (dn) flush = 1;
                end else if (dn) begin
                    exp_data = word_exp(nw - 1);
                    exp_vld  = 1'b1;
                    in_frame = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (chk_en) begin
                check("vld_pr", {31'b0, bus.vld_pr},
                      {31'b0, exp_vld});
                check("data", bus.data_from_processor, exp_data);
            end
            if (bus.vld_pr === 1'b1) begin
                got.push_back(bus.data_from_processor);
                gcyc.push_back(ncyc);
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] d,
                       input logic [1:0] m, input logic [7:0] t,
                       input logic dn);
        bus.scheduler_2_proc_vld = v;
        bus.data_to_processor    = d;
        bus.mode                 = m;
        bus.data_proc            = t;
        bus.done                 = dn;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 2'b00, 8'h00, 0);
    endtask

    task automatic clr();
        got.delete();
        gcyc.delete();
    endtask

    task automatic chk_out(input string nm, input logic [31:0] e[$],
                           input bit back2back);
        check({nm, "_cnt"}, 32'(got.size()), 32'(e.size()));
        for (int i = 0; i < e.size(); i++)
            check(nm, (i < got.size()) ? got[i] : 32'hxxxxxxxx, e[i]);
        if (back2back && e.size() > 1 && got.size() == e.size())
            check({nm, "_gap"}, 32'(gcyc[e.size()-1] - gcyc[0]),
                  32'(e.size() - 1));
    endtask

    initial begin
        logic [31:0] e[$];
        logic [1:0]  rm;
        int          r;
        bus.scheduler_2_proc_vld = 0;
        bus.data_to_processor    = '0;
        bus.mode                 = 2'b00;
        bus.data_proc            = 8'h00;
        bus.done                 = 0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        idle(2);
        rst_n = 1'b0;
        chk_en = 1;
        check("rst_vld", {31'b0, bus.vld_pr}, 32'h0);
        check("rst_data", bus.data_from_processor, 32'h0);

        clr();
        cyc(1, 32'hFF302010, 2'b01, 8'h80, 0);
        cyc(1, 32'h0000FFFF, 2'b01, 8'h80, 0);
        cyc(1, 32'h00000000, 2'b01, 8'h80, 1);
        idle(4);
        e = '{32'hFF000000, 32'h0000FFFF, 32'h00000000};
        chk_out("thr3", e, 1);

        clr();
        cyc(1, 32'h40C08040, 2'b10, 8'h00, 0);
        cyc(1, 32'h0000C080, 2'b10, 8'h00, 0);
        cyc(1, 32'h00000000, 2'b10, 8'h00, 1);
        idle(4);
        e = '{32'h80808080, 32'h00008080, 32'h00000000};
        chk_out("gray3", e, 1);

        clr();
        cyc(1, 32'h11223344, 2'b01, 8'h80, 0);
        cyc(0, 32'h00000000, 2'b01, 8'h80, 1);
        check("single_vld", {31'b0, bus.vld_pr}, 32'h1);
        check("single_data", bus.data_from_processor, 32'h11000000);
        idle(3);
        e = '{32'h11000000};
        chk_out("single", e, 0);

        clr();
        for (int i = 0; i < 3; i++)
            cyc(1, 32'hFFFFFFFF, 2'b00, 8'h80, 0);
        cyc(0, 32'h0, 2'b00, 8'h80, 1);
        idle(3);
        e.delete();
        chk_out("mode0", e, 0);

        clr();
        cyc(1, 32'hFF302010, 2'b01, 8'h80, 0);
        cyc(1, 32'h0000FFFF, 2'b01, 8'h80, 0);
        rst_n = 1'b1;
        cyc(0, 32'h0, 2'b01, 8'h80, 0);
        rst_n = 1'b0;
        check("midrst_vld", {31'b0, bus.vld_pr}, 32'h0);
        check("midrst_data", bus.data_from_processor, 32'h0);
        cyc(0, 32'h0, 2'b01, 8'h80, 1);
        idle(3);
        e = '{32'hFF000000};
        chk_out("midrst", e, 0);

        clr();
        cyc(1, 32'hFF302010, 2'b01, 8'h80, 0);
        cyc(1, 32'h0000FFFF, 2'b10, 8'h10, 0);
        cyc(1, 32'h00000000, 2'b10, 8'h10, 1);
        cyc(1, 32'hFFFFFFFF, 2'b10, 8'h10, 0);
        idle(4);
        e = '{32'hFF000000, 32'h0000FFFF, 32'h00000000};
        chk_out("modesw", e, 1);

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) == 0);
            r = $urandom_range(0, 9);
            rm = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 :
                 (r == 8) ? 2'b11 : 2'b00;
            cyc($urandom_range(0, 9) < 7, $urandom, rm,
                8'($urandom), $urandom_range(0, 9) == 0);
        end
        rst_n = 1'b0;
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bmp_pixel_proc.md
BMP_PIXEL_PROC -- requirements
Module: bmp_pixel_proc

Interface
REQ-001 SHALL have parameter DATA_BUS_SIZE, default 32, input/output word width in bits (4 bytes per word).
REQ-002 SHALL have parameter BYTES_PER_PIXEL, default 3, pixel size in bytes (24-bit BMP, byte order B,G,R).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-high (name kept per codebase; asserted = 1).
REQ-005 data_to_processor  input  DATA_BUS_SIZE  pixel-array word from scheduler; byte 0 = bits [7:0].
REQ-006 scheduler_2_proc_vld  input  1  data_to_processor valid this cycle.
REQ-007 mode  input  2  01 = threshold, 10 = grayscale, 00/11 = idle.
REQ-008 data_proc  input  8  threshold value (used in mode 01).
REQ-009 done  input  1  one-cycle pulse: current frame's last word has been delivered.
REQ-010 data_from_processor  output  DATA_BUS_SIZE  processed word.
REQ-011 vld_pr  output  1  data_from_processor valid; one cycle per word.

Function
REQ-012 Input carries pixel bytes only (no header); the byte stream is cut into consecutive 3-byte pixels starting at byte 0 of the frame's first word; pixels may straddle word boundaries.
REQ-013 Per pixel: luma = (B + 2*G + R) >> 2, computed in 10 bits, result 8 bits.
REQ-014 Mode 01: all 3 output bytes = 0xFF if luma >= data_proc, else 0x00; mode 10: all 3 output bytes = luma.
REQ-015 Byte count preserved: output byte k of the frame is the transform of input byte k's pixel; output word n holds bytes 4n..4n+3.
REQ-016 mode and data_proc latched on the first accepted word of a frame; changes mid-frame ignored until next frame.
REQ-017 Valid word with mode 00 or 11 in IDLE is dropped; no output.
REQ-018 FSM states: IDLE, FIRST (one word held, none emitted), STREAM, FLUSH.
REQ-019 IDLE -> FIRST on valid word with mode 01/10; FIRST -> STREAM on next valid word; STREAM stays on valid words.
REQ-020 Latency: output word n asserted with vld_pr in the cycle after input word n+1 is accepted.
REQ-021 done in FIRST/STREAM without valid: next cycle emit held word, -> IDLE.
REQ-022 done together with valid: accept word as last; next cycle emit previously held word, enter FLUSH; following cycle emit last word, -> IDLE.
REQ-023 At flush, bytes of an incomplete trailing pixel (1 or 2 bytes) pass through unmodified.
REQ-024 done in IDLE ignored; valid in FLUSH starts a new frame only after return to IDLE (dropped in FLUSH).
REQ-025 No backpressure: at most one output per cycle; sustained input of one word per cycle yields one output per cycle.
REQ-026 data_from_processor holds last value when vld_pr = 0.

Reset
REQ-027 rst_n = 1 at a clock edge: state IDLE, held words/carry bytes cleared, latched mode = 00, threshold = 0x00, vld_pr = 0, data_from_processor = 0.
REQ-028 Reset mid-frame discards frame; no output until a new frame starts after rst_n = 0.

Structure
REQ-029 Shared package bmp_pkg SHALL hold DATA_BUS_SIZE, BYTES_PER_PIXEL, mode encodings (MODE_IDLE, MODE_THRESH, MODE_GRAY), BMP header size (54), FSM state typedef.
REQ-030 One combinational sub-module bmp_pixel_xform: (B,G,R,mode,threshold) -> 3 output bytes; instantiated per pixel slot of the two-word window.

Verification
REQ-031 Threshold 0x80, words 0xFF302010, 0x0000FFFF, 0x00000000 (done with 3rd) -> outputs 0xFF000000, 0x0000FFFF, 0x00000000 on three consecutive vld_pr.
REQ-032 Grayscale, words 0x40C08040, 0x0000C080, 0x00000000 + done -> pixels (40,80,C0) luma 0x80 -> 0x80808080, 0x00008080, 0x00000000.
REQ-033 Threshold 0x80, single word 0x11223344 then done -> luma 0x33 -> output 0x11000000 (byte 3 passthrough) one cycle after done.
REQ-034 Mode 00 with valid words 0xFFFFFFFF x3 -> vld_pr stays 0.
REQ-035 Threshold frame, rst_n = 1 after 2 words -> vld_pr = 0 and output 0 next cycle; subsequent done produces no output.
REQ-036 Mode switched 01 -> 10 after first word -> whole frame processed as threshold.
